// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM stage; stalls the pipe until done.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_EN.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_done,
  output logic        mem_misalign
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'((LATENCY > 1) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic                    lat_we;
  logic [DEPTH_LOG2-1:0]   lat_idx;
  logic [31:0]             lat_wdata;
  logic [31:0]             mem [DEPTH];

  logic [DEPTH_LOG2-1:0]   in_idx;
  logic                    mis_in;
  logic                    accept;
  logic                    acc_now;
  logic                    acc_we;
  logic [DEPTH_LOG2-1:0]   acc_idx;
  logic [31:0]             acc_wdata;
  logic                    unused_addr;

  assign in_idx      = mem_addr[DEPTH_LOG2+1:2];
  assign unused_addr = ^{mem_addr[31:DEPTH_LOG2+2], mem_addr[1:0]};

`ifdef DMEM_MISALIGN_EN
  assign mis_in = |mem_addr[1:0];
`else
  assign mis_in = 1'b0;
`endif

  assign accept = (state == IDLE) && mem_req && !rst;

  // Single-cycle config accesses straight from the inputs at acceptance.
  assign acc_now = (accept && (LATENCY == 1) && !mis_in) ||
                   ((state == BUSY) && (cnt == '0) && !rst);

  assign acc_we    = (state == IDLE) ? mem_we    : lat_we;
  assign acc_idx   = (state == IDLE) ? in_idx    : lat_idx;
  assign acc_wdata = (state == IDLE) ? mem_wdata : lat_wdata;

  assign mem_stall = ((state == IDLE) && mem_req) || (state == BUSY);

  always_ff @(posedge clk) begin
    if (acc_now && acc_we) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      mem_rdata    <= '0;
      mem_done     <= 1'b0;
      mem_misalign <= 1'b0;
    end else begin
      mem_done     <= 1'b0;
      mem_misalign <= 1'b0;
      if (acc_now && !acc_we) begin
        mem_rdata <= mem[acc_idx];
      end
      unique case (state)
        IDLE: begin
          if (mem_req) begin
            lat_we    <= mem_we;
            lat_idx   <= in_idx;
            lat_wdata <= mem_wdata;
            if (mis_in) begin
              state        <= DONE;
              mem_done     <= 1'b1;
              mem_misalign <= 1'b1;
            end else if (LATENCY == 1) begin
              state    <= DONE;
              mem_done <= 1'b1;
            end else begin
              cnt   <= CNT_INIT;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state    <= DONE;
            mem_done <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 and LATENCY=1 instances.
// Misalign expectations follow DMEM_MISALIGN_EN.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req2, req1;
  logic        we;
  logic [31:0] addr, wdata;
  logic [31:0] rdata2, rdata1;
  logic        stall2, stall1;
  logic        done2, done1;
  logic        mis2, mis1;

  int checks;
  int errors;

  dmem_responder u_l2 (
    .clk(clk), .rst(rst), .mem_req(req2), .mem_we(we),
    .mem_addr(addr), .mem_wdata(wdata), .mem_rdata(rdata2),
    .mem_stall(stall2), .mem_done(done2), .mem_misalign(mis2)
  );

  dmem_responder #(.DEPTH_LOG2(12), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .mem_req(req1), .mem_we(we),
    .mem_addr(addr), .mem_wdata(wdata), .mem_rdata(rdata1),
    .mem_stall(stall1), .mem_done(done1), .mem_misalign(mis1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic l2_req(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input string nm);
    we = w; addr = a; wdata = d; req2 = 1'b1;
    #1;
    checks++;
    if (stall2 !== 1'b1) begin
      errors++;
      $display("FAIL %s stall_idle got %b want 1", nm, stall2);
    end
    tick();
    req2 = 1'b0;
    checks++;
    if (stall2 !== 1'b1 || done2 !== 1'b0) begin
      errors++;
      $display("FAIL %s busy got stall=%b done=%b want 1/0", nm, stall2, done2);
    end
    tick();
    checks++;
    if (done2 !== 1'b1 || stall2 !== 1'b0 || mis2 !== 1'b0) begin
      errors++;
      $display("FAIL %s done got done=%b stall=%b mis=%b want 1/0/0",
               nm, done2, stall2, mis2);
    end
    tick();
    checks++;
    if (done2 !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse got %b want 0", nm, done2);
    end
  endtask

  task automatic l1_req(input logic w, input logic [31:0] a,
                        input logic [31:0] d);
    we = w; addr = a; wdata = d; req1 = 1'b1;
    tick();
    req1 = 1'b0;
    checks++;
    if (done1 !== 1'b1 || stall1 !== 1'b0) begin
      errors++;
      $display("FAIL l1_req got done=%b stall=%b want 1/0", done1, stall1);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (rdata2 !== 32'h0 || done2 !== 1'b0 || mis2 !== 1'b0 || stall2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_l2 got rdata=%h done=%b mis=%b stall=%b want 0",
               rdata2, done2, mis2, stall2);
    end
    checks++;
    if (rdata1 !== 32'h0 || done1 !== 1'b0 || mis1 !== 1'b0 || stall1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_l1 got rdata=%h done=%b mis=%b stall=%b want 0",
               rdata1, done1, mis1, stall1);
    end
  endtask

  task automatic test_store_load();
    l2_req(1'b1, 32'h10, 32'hDEADBEEF, "store10");
    checks++;
    if (rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL store_keeps_rdata got %h want 0", rdata2);
    end
    l2_req(1'b0, 32'h10, 32'h0, "load10");
    checks++;
    if (rdata2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL load10 got %h want deadbeef", rdata2);
    end
  endtask

  task automatic test_wrap();
    l2_req(1'b1, 32'h4000, 32'h5, "store4000");
    l2_req(1'b0, 32'h0, 32'h0, "load0");
    checks++;
    if (rdata2 !== 32'h5) begin
      errors++;
      $display("FAIL wrap got %h want 5", rdata2);
    end
    l2_req(1'b1, 32'h8, 32'h7, "store8");
    checks++;
    if (rdata2 !== 32'h5) begin
      errors++;
      $display("FAIL rdata_hold got %h want 5", rdata2);
    end
  endtask

  task automatic test_reset_abort();
    l2_req(1'b1, 32'h20, 32'hAAAA, "store20");
    we = 1'b1; addr = 32'h20; wdata = 32'h1234; req2 = 1'b1;
    tick();
    req2 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (done2 !== 1'b0 || stall2 !== 1'b0) begin
      errors++;
      $display("FAIL abort got done=%b stall=%b want 0/0", done2, stall2);
    end
    tick();
    checks++;
    if (done2 !== 1'b0) begin
      errors++;
      $display("FAIL abort_nodone got %b want 0", done2);
    end
    l2_req(1'b0, 32'h20, 32'h0, "load20");
    checks++;
    if (rdata2 !== 32'hAAAA) begin
      errors++;
      $display("FAIL abort_old got %h want 0000aaaa", rdata2);
    end
  endtask

  task automatic test_latched();
    l2_req(1'b1, 32'h34, 32'h9999, "store34");
    we = 1'b1; addr = 32'h30; wdata = 32'h1111; req2 = 1'b1;
    tick();
    req2 = 1'b0;
    we = 1'b1; addr = 32'h34; wdata = 32'h2222;
    tick();
    tick();
    l2_req(1'b0, 32'h30, 32'h0, "load30");
    checks++;
    if (rdata2 !== 32'h1111) begin
      errors++;
      $display("FAIL latched30 got %h want 1111", rdata2);
    end
    l2_req(1'b0, 32'h34, 32'h0, "load34");
    checks++;
    if (rdata2 !== 32'h9999) begin
      errors++;
      $display("FAIL latched34 got %h want 9999", rdata2);
    end
  endtask

  task automatic test_back_to_back();
    l1_req(1'b1, 32'h0, 32'h11);
    l1_req(1'b1, 32'h4, 32'h22);
    we = 1'b0; addr = 32'h0; req1 = 1'b1;
    #1;
    checks++;
    if (stall1 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stall0 got %b want 1", stall1);
    end
    tick();
    checks++;
    if (done1 !== 1'b1 || stall1 !== 1'b0 || rdata1 !== 32'h11) begin
      errors++;
      $display("FAIL b2b_done0 got done=%b stall=%b rdata=%h want 1/0/11",
               done1, stall1, rdata1);
    end
    addr = 32'h4;
    tick();
    checks++;
    if (done1 !== 1'b0 || stall1 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle got done=%b stall=%b want 0/1", done1, stall1);
    end
    tick();
    req1 = 1'b0;
    checks++;
    if (done1 !== 1'b1 || stall1 !== 1'b0 || rdata1 !== 32'h22) begin
      errors++;
      $display("FAIL b2b_done1 got done=%b stall=%b rdata=%h want 1/0/22",
               done1, stall1, rdata1);
    end
    tick();
  endtask

  task automatic test_misalign();
    l2_req(1'b1, 32'h4, 32'h4444, "store4");
    l2_req(1'b0, 32'h10, 32'h0, "reload10");
    checks++;
    if (rdata2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL reload10 got %h want deadbeef", rdata2);
    end
`ifdef DMEM_MISALIGN_EN
    we = 1'b0; addr = 32'h6; req2 = 1'b1;
    tick();
    req2 = 1'b0;
    checks++;
    if (done2 !== 1'b1 || mis2 !== 1'b1 || rdata2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL misalign got done=%b mis=%b rdata=%h want 1/1/deadbeef",
               done2, mis2, rdata2);
    end
    tick();
    checks++;
    if (done2 !== 1'b0 || mis2 !== 1'b0) begin
      errors++;
      $display("FAIL misalign_pulse got done=%b mis=%b want 0/0", done2, mis2);
    end
`else
    l2_req(1'b0, 32'h6, 32'h0, "load6");
    checks++;
    if (rdata2 !== 32'h4444 || mis2 !== 1'b0) begin
      errors++;
      $display("FAIL load6 got rdata=%h mis=%b want 4444/0", rdata2, mis2);
    end
`endif
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    req2 = 1'b0; req1 = 1'b0;
    we = 1'b0; addr = '0; wdata = '0;
    checks = 0; errors = 0;
    test_reset();
    test_store_load();
    test_wrap();
    test_reset_abort();
    test_latched();
    test_back_to_back();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
